// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter sharing one UART transmitter among NUM_REQ byte streams.
module uart_tx_arbiter #(
   parameter int unsigned NUM_REQ      = 4,
   parameter int unsigned GAP_CLKS     = 0,
   parameter int unsigned TIMEOUT_CLKS = 8192
) (
   input  logic                   i_Clock,
   input  logic                   i_Reset,
   input  logic [NUM_REQ-1:0]     i_Req,
   input  logic [8*NUM_REQ-1:0]   i_Data,
   input  logic [NUM_REQ-1:0]     i_Last,
   output logic [NUM_REQ-1:0]     o_Ack,
   output logic [NUM_REQ-1:0]     o_Grant,
   output logic                   o_Busy,
   output logic                   o_TX_Start,
   output logic [7:0]             o_TX_Data,
   input  logic                   i_TX_Active,
   input  logic                   i_TX_Done,
   output logic                   o_Timeout
);

   localparam int unsigned IDX_W    = (NUM_REQ < 2) ? 1 : $clog2(NUM_REQ);
   localparam int unsigned TO_W     = (TIMEOUT_CLKS < 2) ? 1 : $clog2(TIMEOUT_CLKS);
   localparam int unsigned GAP_W    = (GAP_CLKS < 2) ? 1 : $clog2(GAP_CLKS);
   // A zero gap still spends one cycle in GAP.
   localparam int unsigned GAP_LAST = (GAP_CLKS == 0) ? 0 : GAP_CLKS - 1;

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_START     = 2'd1,
      S_WAIT_DONE = 2'd2,
      S_GAP       = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   owner_q, owner_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [NUM_REQ-1:0] ack_q, ack_d;
   logic               busy_q, busy_d;
   logic               start_q, start_d;
   logic [7:0]         data_q, data_d;
   logic               timeout_q, timeout_d;
   logic               last_q, last_d;
   logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
   logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;

   logic               pick_found;
   logic [IDX_W-1:0]   pick_idx;
   logic [IDX_W-1:0]   cand;
   logic [IDX_W-1:0]   owner_inc;

   // First requester at or after the round-robin pointer, wrapping.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         cand = IDX_W'((32'(ptr_q) + i) % NUM_REQ);
         if (!pick_found && i_Req[cand]) begin
            pick_found = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   // Pointer value used whenever the current owner gives up the transmitter.
   always_comb begin
      owner_inc = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      ptr_d     = ptr_q;
      grant_d   = grant_q;
      ack_d     = '0;
      start_d   = 1'b0;
      data_d    = data_q;
      timeout_d = 1'b0;
      last_d    = last_q;
      to_cnt_d  = to_cnt_q;
      gap_cnt_d = gap_cnt_q;

      case (state_q)
         S_IDLE: begin
            if (pick_found) begin
               owner_d = pick_idx;
               grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
               state_d = S_START;
            end
         end
         S_START: begin
            if (!i_Req[owner_q]) begin
               grant_d = '0;
               ptr_d   = owner_inc;
               state_d = S_IDLE;
            end else if (!i_TX_Active) begin
               start_d  = 1'b1;
               data_d   = i_Data[{owner_q, 3'b000} +: 8];
               ack_d    = grant_q;
               last_d   = i_Last[owner_q];
               to_cnt_d = '0;
               state_d  = S_WAIT_DONE;
            end
         end
         S_WAIT_DONE: begin
            if (i_TX_Done) begin
               gap_cnt_d = '0;
               state_d   = S_GAP;
            end else if (to_cnt_q == TO_W'(TIMEOUT_CLKS - 1)) begin
               timeout_d = 1'b1;
               grant_d   = '0;
               ptr_d     = owner_inc;
               state_d   = S_IDLE;
            end else begin
               to_cnt_d = to_cnt_q + TO_W'(1);
            end
         end
         S_GAP: begin
            if (gap_cnt_q == GAP_W'(GAP_LAST)) begin
               if (last_q || !i_Req[owner_q]) begin
                  grant_d = '0;
                  ptr_d   = owner_inc;
                  state_d = S_IDLE;
               end else begin
                  state_d = S_START;
               end
            end else begin
               gap_cnt_d = gap_cnt_q + GAP_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         state_q   <= S_IDLE;
         owner_q   <= '0;
         ptr_q     <= '0;
         grant_q   <= '0;
         ack_q     <= '0;
         busy_q    <= 1'b0;
         start_q   <= 1'b0;
         data_q    <= '0;
         timeout_q <= 1'b0;
         last_q    <= 1'b0;
         to_cnt_q  <= '0;
         gap_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         ptr_q     <= ptr_d;
         grant_q   <= grant_d;
         ack_q     <= ack_d;
         busy_q    <= busy_d;
         start_q   <= start_d;
         data_q    <= data_d;
         timeout_q <= timeout_d;
         last_q    <= last_d;
         to_cnt_q  <= to_cnt_d;
         gap_cnt_q <= gap_cnt_d;
      end
   end

   assign o_Ack      = ack_q;
   assign o_Grant    = grant_q;
   assign o_Busy     = busy_q;
   assign o_TX_Start = start_q;
   assign o_TX_Data  = data_q;
   assign o_Timeout  = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: queue-based requesters, a UART_TX timing stub and a transaction model.
module tb_uart_tx_arbiter;

   localparam int N     = 4;
   localparam int GAP   = 4;
   localparam int TMO   = 50;
   localparam int FRAME = 20;

   typedef struct packed {
      logic [7:0] d;
      logic       l;
   } item_t;

   logic             i_Clock;
   logic             i_Reset;
   logic [N-1:0]     i_Req;
   logic [8*N-1:0]   i_Data;
   logic [N-1:0]     i_Last;
   logic [N-1:0]     o_Ack;
   logic [N-1:0]     o_Grant;
   logic             o_Busy;
   logic             o_TX_Start;
   logic [7:0]       o_TX_Data;
   logic             i_TX_Active;
   logic             i_TX_Done;
   logic             o_Timeout;

   logic             stub_active;
   logic             hold_active;
   logic             no_done;
   int               stub_cnt;

   item_t            rq[N][$];
   logic [7:0]       start_log[$];
   int               start_cyc[$];
   logic [7:0]       rx_q[$];

   int               n_checks;
   int               n_errors;
   int               cyc;
   int               grant_fall_cyc;
   int               timeout_cyc;
   int               n_timeouts;

   int               m_ptr;
   int               m_cur;
   logic             m_last_sent;
   logic [N-1:0]     prev_grant;
   logic             rst_edge;

   assign i_TX_Active = stub_active | hold_active;

   uart_tx_arbiter #(
      .NUM_REQ      (N),
      .GAP_CLKS     (GAP),
      .TIMEOUT_CLKS (TMO)
   ) dut (
      .i_Clock     (i_Clock),
      .i_Reset     (i_Reset),
      .i_Req       (i_Req),
      .i_Data      (i_Data),
      .i_Last      (i_Last),
      .o_Ack       (o_Ack),
      .o_Grant     (o_Grant),
      .o_Busy      (o_Busy),
      .o_TX_Start  (o_TX_Start),
      .o_TX_Data   (o_TX_Data),
      .i_TX_Active (i_TX_Active),
      .i_TX_Done   (i_TX_Done),
      .o_Timeout   (o_Timeout)
   );

   initial begin
      i_Clock = 1'b0;
      forever #5 i_Clock = ~i_Clock;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Present each requester's queue head on the request bus.
   function automatic void drive_reqs();
      for (int r = 0; r < N; r++) begin
         if (rq[r].size() != 0) begin
            i_Req[r]          = 1'b1;
            i_Data[8*r +: 8]  = rq[r][0].d;
            i_Last[r]         = rq[r][0].l;
         end else begin
            i_Req[r]          = 1'b0;
            i_Data[8*r +: 8]  = 8'h00;
            i_Last[r]         = 1'b0;
         end
      end
   endfunction

   function automatic void push(input int r, input logic [7:0] d, input logic l);
      item_t it;
      it.d = d;
      it.l = l;
      rq[r].push_back(it);
   endfunction

   // Round-robin choice over requesters with pending bytes.
   function automatic int m_pick();
      for (int i = 0; i < N; i++) begin
         int r;
         r = (m_ptr + i) % N;
         if (rq[r].size() != 0) return r;
      end
      return -1;
   endfunction

   // Requesters: pop the head on ack, then present the next byte.
   initial begin
      forever begin
         @(posedge i_Clock);
         #2;
         for (int r = 0; r < N; r++)
            if (o_Ack[r] && rq[r].size() != 0) void'(rq[r].pop_front());
         drive_reqs();
      end
   end

   // UART_TX stub: FRAME cycles from start pulse to done pulse; captures the byte at done.
   initial begin
      stub_active = 1'b0;
      i_TX_Done   = 1'b0;
      stub_cnt    = 0;
      forever begin
         @(posedge i_Clock);
         #2;
         i_TX_Done = 1'b0;
         if (stub_cnt > 0) begin
            stub_cnt--;
            if (stub_cnt == 0) begin
               i_TX_Done   = 1'b1;
               stub_active = 1'b0;
               rx_q.push_back(o_TX_Data);
            end
         end
         if (o_TX_Start && !no_done) begin
            stub_active = 1'b1;
            stub_cnt    = FRAME;
         end
      end
   end

   // Compare process: invariants every cycle, transaction model at each start and release.
   initial begin
      forever begin
         @(posedge i_Clock);
         rst_edge = i_Reset;
         #1;
         cyc++;
         if (rst_edge) begin
            chk("rst_grant", 32'(o_Grant), 0);
            chk("rst_outputs", {o_Busy, o_TX_Start, o_Timeout, o_Ack, o_TX_Data}, 0);
            m_ptr       = 0;
            m_cur       = -1;
            m_last_sent = 1'b0;
            prev_grant  = '0;
         end else begin
            chk("busy_vs_grant", 32'(o_Busy), 32'(|o_Grant));
            chk("grant_onehot", 32'($countones(o_Grant) <= 1), 1);
            chk("ack_vs_start", 32'(o_Ack), o_TX_Start ? 32'(o_Grant) : 0);
            if (o_TX_Start) begin
               chk("start_no_timeout", 32'(o_Timeout), 0);
               if (m_cur < 0) m_cur = m_pick();
               chk("start_has_req", 32'(m_cur >= 0), 1);
               if (m_cur >= 0) begin
                  chk("start_owner", 32'(o_Grant), 32'(1) << m_cur);
                  chk("start_data", 32'(o_TX_Data), 32'(rq[m_cur][0].d));
                  m_last_sent = rq[m_cur][0].l;
               end
               start_log.push_back(o_TX_Data);
               start_cyc.push_back(cyc);
            end
            if (o_Timeout) begin
               timeout_cyc = cyc;
               n_timeouts++;
            end
            if (prev_grant != '0 && o_Grant == '0) begin
               grant_fall_cyc = cyc;
               chk("release_reason", 32'(m_last_sent || o_Timeout), 1);
               if (m_cur >= 0) m_ptr = (m_cur + 1) % N;
               m_cur       = -1;
               m_last_sent = 1'b0;
            end else if (o_Grant != '0 && m_cur >= 0) begin
               chk("grant_owner", 32'(o_Grant), 32'(1) << m_cur);
            end
            prev_grant = o_Grant;
         end
      end
   end

   task automatic wait_starts(input int n, input string tag);
      int t;
      t = 0;
      while (start_log.size() < n && t < 3000) begin
         @(negedge i_Clock);
         t++;
      end
      chk(tag, 32'(start_log.size() >= n), 1);
   endtask

   task automatic wait_idle(input string tag);
      int t;
      logic pend;
      t = 0;
      forever begin
         pend = 1'b0;
         for (int r = 0; r < N; r++) if (rq[r].size() != 0) pend = 1'b1;
         if (!(pend || o_Busy) || t >= 3000) break;
         @(negedge i_Clock);
         t++;
      end
      chk(tag, 32'(t < 3000), 1);
   endtask

   task automatic clear_logs();
      start_log.delete();
      start_cyc.delete();
      rx_q.delete();
   endtask

   task automatic do_reset(input int cycles);
      @(negedge i_Clock);
      i_Reset = 1'b1;
      for (int r = 0; r < N; r++) rq[r].delete();
      drive_reqs();
      repeat (cycles) @(negedge i_Clock);
      i_Reset = 1'b0;
   endtask

   initial begin
      int c0;
      int t;
      int t0;
      n_checks       = 0;
      n_errors       = 0;
      cyc            = 0;
      grant_fall_cyc = 0;
      timeout_cyc    = 0;
      n_timeouts     = 0;
      m_ptr          = 0;
      m_cur          = -1;
      m_last_sent    = 1'b0;
      prev_grant     = '0;
      hold_active    = 1'b0;
      no_done        = 1'b0;
      i_Reset        = 1'b1;
      i_Req          = '0;
      i_Data         = '0;
      i_Last         = '0;

      // Reset state.
      repeat (3) @(negedge i_Clock);
      chk("reset_grant", 32'(o_Grant), 0);
      chk("reset_busy", 32'(o_Busy), 0);
      chk("reset_data", 32'(o_TX_Data), 0);
      i_Reset = 1'b0;
      @(negedge i_Clock);

      // Single byte: start two cycles after request, grant clears after done + gap.
      clear_logs();
      push(0, 8'h3F, 1'b1);
      drive_reqs();
      c0 = cyc;
      wait_starts(1, "single_start_seen");
      chk("single_latency", 32'(start_cyc[0] - c0), 2);
      chk("single_data", 32'(start_log[0]), 32'h3F);
      wait_idle("single_idle");
      chk("single_rx", (rx_q.size() == 1) ? 32'(rx_q[0]) : 32'h1FF, 32'h3F);
      chk("single_grant_clear", 32'(grant_fall_cyc - start_cyc[0]), 32'(FRAME + 1 + GAP));

      // Fairness: one byte per requester per round, starting from pointer 0.
      do_reset(2);
      @(negedge i_Clock);
      clear_logs();
      push(0, 8'h10, 1'b1);
      push(0, 8'h11, 1'b1);
      push(1, 8'h21, 1'b1);
      push(2, 8'h32, 1'b1);
      push(3, 8'h43, 1'b1);
      drive_reqs();
      wait_starts(5, "fair_starts_seen");
      wait_idle("fair_idle");
      chk("fair_order", {start_log[0], start_log[1], start_log[2], start_log[3]}, 32'h10213243);
      chk("fair_fifth", 32'(start_log[4]), 32'h11);

      // Packet lock and inter-byte gap: requester 1 keeps the grant for its 3-byte packet.
      clear_logs();
      push(1, 8'hA0, 1'b0);
      push(1, 8'hA1, 1'b0);
      push(1, 8'hA2, 1'b1);
      push(2, 8'hB0, 1'b1);
      drive_reqs();
      wait_starts(4, "lock_starts_seen");
      wait_idle("lock_idle");
      chk("lock_order", {start_log[0], start_log[1], start_log[2], start_log[3]}, 32'hA0A1A2B0);
      chk("gap_spacing", 32'(start_cyc[1] - start_cyc[0]), 32'(FRAME + GAP + 2));
      chk("gap_spacing2", 32'(start_cyc[2] - start_cyc[1]), 32'(FRAME + GAP + 2));

      // Transmitter still active: START holds until it drops.
      clear_logs();
      hold_active = 1'b1;
      push(3, 8'hC3, 1'b1);
      drive_reqs();
      repeat (12) @(negedge i_Clock);
      chk("hold_no_start", 32'(start_log.size()), 0);
      chk("hold_grant", 32'(o_Grant), 32'h8);
      hold_active = 1'b0;
      c0 = cyc;
      wait_starts(1, "hold_start_seen");
      chk("hold_release_latency", 32'(start_cyc[0] - c0), 1);
      chk("hold_data", 32'(start_log[0]), 32'hC3);
      wait_idle("hold_idle");

      // Timeout: no done from the transmitter, next requester served after expiry.
      clear_logs();
      no_done = 1'b1;
      t0 = n_timeouts;
      push(0, 8'hD0, 1'b1);
      push(1, 8'hE1, 1'b1);
      drive_reqs();
      t = 0;
      while (n_timeouts == t0 && t < 3000) begin
         @(negedge i_Clock);
         t++;
      end
      no_done = 1'b0;
      chk("timeout_seen", 32'(n_timeouts - t0), 1);
      chk("timeout_delay", 32'(timeout_cyc - start_cyc[0]), 32'(TMO));
      chk("timeout_grant_drop", 32'(grant_fall_cyc), 32'(timeout_cyc));
      wait_starts(2, "timeout_next_seen");
      chk("timeout_next_delay", 32'(start_cyc[1] - start_cyc[0]), 32'(TMO + 2));
      chk("timeout_order", {16'h0, start_log[0], start_log[1]}, 32'hD0E1);
      wait_idle("timeout_idle");

      // Reset mid-packet: abandon, pointer back to 0, fresh requests served normally.
      clear_logs();
      push(2, 8'hF0, 1'b0);
      push(2, 8'hF1, 1'b0);
      push(2, 8'hF2, 1'b1);
      drive_reqs();
      wait_starts(2, "midrst_starts_seen");
      repeat (3) @(negedge i_Clock);
      chk("midrst_busy_before", 32'(o_Busy), 1);
      do_reset(1);
      chk("midrst_grant", 32'(o_Grant), 0);
      chk("midrst_outputs", {o_Busy, o_TX_Start, o_Timeout, o_Ack, o_TX_Data}, 0);
      @(negedge i_Clock);
      clear_logs();
      push(1, 8'h55, 1'b1);
      push(3, 8'h77, 1'b1);
      drive_reqs();
      wait_starts(2, "midrst_fresh_seen");
      chk("midrst_order", {16'h0, start_log[0], start_log[1]}, 32'h5577);
      wait_idle("midrst_idle");

      repeat (3) @(negedge i_Clock);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got %0d cycles, expected completion", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
